// File: rtl/rca_addsub.sv
// Legacy add/sub unit package retained for compatibility; the pipelined top is rca_addsub_pipe.
package rca_addsub_unused_pkg;
  localparam int RCA_ADDSUB_UNUSED = 0;
endpackage

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  // Operation select carried alongside each beat.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } rca_op_e;

  // Number of ripple slices (pipeline stages) needed to cover `width` bits.
  function automatic int rca_stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// One combinational ripple slice of N full adders. Also exposes the carry
// into the top bit so the final slice can derive signed overflow.
module rca_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  // Ripple the carry LSB to MSB; c_msb_in ends up holding the carry into bit N-1.
  always_comb begin
    logic c;
    c        = cin;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < N; i++) begin
      c_msb_in = c;
      s[i]     = a[i] ^ b[i] ^ c;
      c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_addsub_pipe.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready handshake.
// The carry chain is cut into CHUNK-bit slices with a register after each
// slice; latency is STAGES cycles, throughput one beat per cycle.
// Optional build macro RCA_PIPE_SAT_EN: clamp the result to signed max/min
// on overflow (applied when loading the final stage register).
module rca_addsub_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int STAGES = rca_stages(WIDTH, CHUNK);
  localparam int LAST_W = WIDTH - (STAGES - 1) * CHUNK;

`ifdef RCA_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Per-stage registers: finished low result bits, ripple carry, skewed
  // operands (B already conditionally inverted), op and valid.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             op_q    [STAGES];
  logic             op_d    [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  // What each slice sees (input beat for slice 0, previous stage otherwise)
  // and what it produces.
  logic             v_in_w   [STAGES];
  logic             op_in_w  [STAGES];
  logic             cin_w    [STAGES];
  logic [WIDTH-1:0] a_in_w   [STAGES];
  logic [WIDTH-1:0] b_in_w   [STAGES];
  logic [WIDTH-1:0] res_in_w [STAGES];
  logic [WIDTH-1:0] res_w    [STAGES];
  logic             cout_w   [STAGES];
  logic             cmsb_w   [STAGES];

  logic stall;

  // A held, unconsumed output freezes the whole pipe.
  assign stall    = valid_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;
    localparam int SW = (gi == STAGES - 1) ? LAST_W : CHUNK;

    logic [SW-1:0] s_loc;

    if (gi == 0) begin : g_head
      assign v_in_w[gi]   = in_valid;
      assign op_in_w[gi]  = op;
      assign cin_w[gi]    = (op == OP_SUB);
      assign a_in_w[gi]   = a;
      assign b_in_w[gi]   = b ^ {WIDTH{op == OP_SUB}};
      assign res_in_w[gi] = '0;
    end else begin : g_body
      assign v_in_w[gi]   = valid_q[gi-1];
      assign op_in_w[gi]  = op_q[gi-1];
      assign cin_w[gi]    = carry_q[gi-1];
      assign a_in_w[gi]   = a_q[gi-1];
      assign b_in_w[gi]   = b_q[gi-1];
      assign res_in_w[gi] = res_q[gi-1];
    end

    rca_slice #(.N(SW)) u_slice (
      .a        (a_in_w[gi][LO +: SW]),
      .b        (b_in_w[gi][LO +: SW]),
      .cin      (cin_w[gi]),
      .s        (s_loc),
      .cout     (cout_w[gi]),
      .c_msb_in (cmsb_w[gi])
    );

    // Bits above this slice are still zero, so OR-ing in the new bits is enough.
    assign res_w[gi] = res_in_w[gi] | (WIDTH'(s_loc) << LO);
  end

  // Advance every stage by one when not stalled; otherwise hold everything.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      op_d[k]    = op_q[k];
      carry_d[k] = carry_q[k];
      res_d[k]   = res_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
    end
    ovf_d = ovf_q;
    if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_d[k] = v_in_w[k];
        op_d[k]    = op_in_w[k];
        carry_d[k] = cout_w[k];
        res_d[k]   = res_w[k];
        a_d[k]     = a_in_w[k];
        b_d[k]     = b_in_w[k];
      end
      ovf_d = cout_w[STAGES-1] ^ cmsb_w[STAGES-1];
`ifdef RCA_PIPE_SAT_EN
      if (cout_w[STAGES-1] ^ cmsb_w[STAGES-1]) begin
        res_d[STAGES-1] = a_in_w[STAGES-1][WIDTH-1] ? SMIN : SMAX;
      end
`endif
    end
  end

  // Stage registers; reset discards every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        op_q[k]    <= 1'b0;
        carry_q[k] <= 1'b0;
        res_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        op_q[k]    <= op_d[k];
        carry_q[k] <= carry_d[k];
        res_q[k]   <= res_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_addsub_pipe.sv
// Self-checking bench for rca_addsub_pipe: a 16/4 instance and a 9/4 instance
// checked against an arithmetic reference model.
module tb_rca_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        in_valid16, in_ready16, op16, out_valid16, out_ready16, carry16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid9, in_ready9, op9, out_valid9, out_ready9, carry9, ovf9;
  logic [8:0]  a9, b9, sum9;

  int n_cmp = 0;
  int n_err = 0;

  rca_addsub_pipe #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .carry(carry16), .ovf(ovf16)
  );

  rca_addsub_pipe #(.WIDTH(9), .CHUNK(4)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid9), .in_ready(in_ready9),
    .a(a9), .b(b9), .op(op9), .out_valid(out_valid9), .out_ready(out_ready9),
    .sum(sum9), .carry(carry9), .ovf(ovf9)
  );

  // Reference: {ovf, carry, sum} from plain unsigned/signed integer arithmetic.
  function automatic logic [17:0] ref_model(input int w, input longint av, input longint bv, input bit o);
    longint m, full, sa, sb, r, smax, smin;
    logic c, f;
    logic [15:0] s;
    m    = (64'sd1 <<< w) - 1;
    smax = (64'sd1 <<< (w - 1)) - 1;
    smin = -(64'sd1 <<< (w - 1));
    full = o ? av + ((~bv) & m) + 1 : av + bv;
    c    = ((full >>> w) & 1) != 0;
    s    = 16'(full & m);
    sa   = (av > smax) ? av - (m + 1) : av;
    sb   = (bv > smax) ? bv - (m + 1) : bv;
    r    = o ? sa - sb : sa + sb;
    f    = (r > smax) || (r < smin);
`ifdef RCA_PIPE_SAT_EN
    if (f) s = 16'((r > smax) ? smax : (smin & m));
`endif
    return {f, c, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input bit v, input logic [15:0] av, input logic [15:0] bv,
                       input bit o, input bit rdy);
    if (sel == 0) begin
      in_valid16 = v; a16 = av; b16 = bv; op16 = o; out_ready16 = rdy;
    end else begin
      in_valid9 = v; a9 = av[8:0]; b9 = bv[8:0]; op9 = o; out_ready9 = rdy;
    end
  endtask

  task automatic observe(input int sel, output logic ov, output logic ir, output logic [17:0] res);
    if (sel == 0) begin
      ov = out_valid16; ir = in_ready16; res = {ovf16, carry16, sum16};
    end else begin
      ov = out_valid9; ir = in_ready9; res = {ovf9, carry9, 7'd0, sum9};
    end
  endtask

  task automatic test_reset();
    logic ov, ir;
    logic [17:0] res;
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      observe(s, ov, ir, res);
      n_cmp++;
      if (ov !== 1'b0 || res !== 18'd0 || ir !== 1'b1) begin
        n_err++;
        $display("FAIL por_state[dut%0d]: got valid=%b res=%h ready=%b expected valid=0 res=0 ready=1", s, ov, res, ir);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      drive(1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      observe(s, ov, ir, res);
      n_cmp++;
      if (ov !== 1'b0 || res !== 18'd0 || ir !== 1'b1) begin
        n_err++;
        $display("FAIL midstream_reset[dut%0d]: got valid=%b res=%h ready=%b expected valid=0 res=0 ready=1", s, ov, res, ir);
      end
    end
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    #1;
    observe(0, ov, ir, res);
    n_cmp++;
    if (ov !== 1'b0 || res !== 18'd0 || ir !== 1'b1) begin
      n_err++;
      $display("FAIL post_release: got valid=%b res=%h ready=%b expected valid=0 res=0 ready=1", ov, res, ir);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        observe(s, ov, ir, res);
        n_cmp++;
        if (ov !== 1'b0) begin
          n_err++;
          $display("FAIL stale_beat[dut%0d cyc%0d]: got out_valid=%b expected 0", s, i, ov);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vo [3];
    logic [17:0] vexp [3];
    logic ov, ir;
    logic [17:0] res;
    int lat;
    va = '{16'hFFFF, 16'h8000, 16'h7FFF};
    vb = '{16'h0001, 16'h0001, 16'h0001};
    vo = '{1'b0, 1'b1, 1'b0};
`ifdef RCA_PIPE_SAT_EN
    vexp = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b1, 16'h8000}, {1'b1, 1'b0, 16'h7FFF}};
`else
    vexp = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b1, 16'h7FFF}, {1'b1, 1'b0, 16'h8000}};
`endif
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, va[i], vb[i], vo[i], 1'b1);
      #1;
      observe(0, ov, ir, res);
      n_cmp++;
      if (ir !== 1'b1) begin
        n_err++;
        $display("FAIL directed_ready[%0d]: got %b expected 1", i, ir);
      end
      tick();
      drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      lat = 1;
      observe(0, ov, ir, res);
      while (ov !== 1'b1 && lat < 20) begin
        tick();
        lat++;
        observe(0, ov, ir, res);
      end
      n_cmp++;
      if (lat != 4) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
      end
      n_cmp++;
      if (res !== vexp[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got ovf/carry/sum=%h expected %h", i, res, vexp[i]);
      end
      tick();
      observe(0, ov, ir, res);
      n_cmp++;
      if (ov !== 1'b0) begin
        n_err++;
        $display("FAIL directed_single_beat[%0d]: got out_valid=%b expected 0", i, ov);
      end
    end
  endtask

  task automatic test_odd_width();
    logic ov, ir;
    logic [17:0] res;
    int lat;
    drive(1, 1'b1, 16'h01FF, 16'h0001, 1'b1, 1'b1);
    tick();
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    lat = 1;
    observe(1, ov, ir, res);
    while (ov !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      observe(1, ov, ir, res);
    end
    n_cmp++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL odd_latency: got %0d expected 3", lat);
    end
    n_cmp++;
    if (res !== {1'b0, 1'b1, 16'h01FE}) begin
      n_err++;
      $display("FAIL odd_result: got ovf/carry/sum=%h expected %h", res, {1'b0, 1'b1, 16'h01FE});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [17:0] expq [$];
    logic ov, ir, rdy, v, prev_stall;
    logic [17:0] res, prev_res, want;
    logic [15:0] av, bv;
    logic o;
    int sent, got;
    bit exp_ov, exp_ir;
    sent = 0; got = 0; prev_stall = 1'b0; prev_res = '0;
    for (int i = 0; i < 20; i++) begin
      observe(0, ov, ir, res);
      exp_ov = (i >= 4 && i <= 15);
      n_cmp++;
      if (ov !== exp_ov) begin
        n_err++;
        $display("FAIL bp_out_valid[cyc%0d]: got %b expected %b", i, ov, exp_ov);
      end
      if (prev_stall) begin
        n_cmp++;
        if (res !== prev_res) begin
          n_err++;
          $display("FAIL bp_hold[cyc%0d]: got %h expected %h", i, res, prev_res);
        end
      end
      rdy = !(i >= 5 && i <= 8);
      v = (sent < 8);
      av = 16'($urandom); bv = 16'($urandom); o = 1'($urandom);
      drive(0, v, av, bv, o, rdy);
      #1;
      observe(0, ov, ir, res);
      exp_ir = !(i >= 5 && i <= 8);
      n_cmp++;
      if (ir !== exp_ir) begin
        n_err++;
        $display("FAIL bp_in_ready[cyc%0d]: got %b expected %b", i, ir, exp_ir);
      end
      if (v && exp_ir) begin
        expq.push_back(ref_model(16, longint'(av), longint'(bv), o));
        sent++;
      end
      if (ov === 1'b1 && rdy) begin
        want = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
        n_cmp++;
        if (res !== want) begin
          n_err++;
          $display("FAIL bp_result[%0d]: got %h expected %h", got, res, want);
        end
        got++;
      end
      prev_stall = (ov === 1'b1) && !rdy;
      prev_res = res;
      tick();
    end
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_cmp++;
    if (got != 8 || sent != 8) begin
      n_err++;
      $display("FAIL bp_count: got %0d out / %0d in expected 8 / 8", got, sent);
    end
  endtask

  task automatic test_random(input int sel, input int nbeats);
    logic [17:0] expq [$];
    logic ov, ir, rdy, v, o, prev_stall;
    logic [17:0] res, prev_res, want;
    logic [15:0] av, bv, msk;
    int w, sent, got, cycles, limit;
    w = (sel == 0) ? 16 : 9;
    msk = (sel == 0) ? 16'hFFFF : 16'h01FF;
    sent = 0; got = 0; cycles = 0; limit = nbeats * 8 + 100;
    prev_stall = 1'b0; prev_res = '0;
    while (got < nbeats && cycles < limit) begin
      observe(sel, ov, ir, res);
      if (prev_stall) begin
        n_cmp++;
        if (ov !== 1'b1 || res !== prev_res) begin
          n_err++;
          $display("FAIL rnd_hold[dut%0d cyc%0d]: got valid=%b res=%h expected valid=1 res=%h", sel, cycles, ov, res, prev_res);
        end
      end
      v = (sent < nbeats) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      av = 16'($urandom) & msk; bv = 16'($urandom) & msk; o = 1'($urandom);
      drive(sel, v, av, bv, o, rdy);
      #1;
      observe(sel, ov, ir, res);
      n_cmp++;
      if (ir !== !(ov === 1'b1 && !rdy)) begin
        n_err++;
        $display("FAIL rnd_in_ready[dut%0d cyc%0d]: got %b expected %b", sel, cycles, ir, !(ov === 1'b1 && !rdy));
      end
      if (v && ir === 1'b1) begin
        expq.push_back(ref_model(w, longint'(av), longint'(bv), o));
        sent++;
      end
      if (ov === 1'b1 && rdy) begin
        want = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
        n_cmp++;
        if (res !== want) begin
          n_err++;
          $display("FAIL rnd_result[dut%0d beat%0d]: got %h expected %h (a=%h b=%h)", sel, got, res, want, av, bv);
        end
        got++;
      end
      prev_stall = (ov === 1'b1) && !rdy;
      prev_res = res;
      tick();
      cycles++;
    end
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_cmp++;
    if (got != nbeats) begin
      n_err++;
      $display("FAIL rnd_timeout[dut%0d]: got %0d beats expected %0d", sel, got, nbeats);
    end
    repeat (6) tick();
    observe(sel, ov, ir, res);
    n_cmp++;
    if (ov !== 1'b0 || expq.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain[dut%0d]: got valid=%b pending=%0d expected valid=0 pending=0", sel, ov, expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_odd_width();
    test_random(0, 500);
    test_random(1, 10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
